// File: rtl/light_level_sched.sv
`default_nettype none
// ============================================================================
// Module : light_level_sched
// Brief  : Round-robin scheduler stepping a 4-level light toward requested levels.
// Rev    : 1.0
// ============================================================================
module light_level_sched #(
    parameter int STEP_DELAY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [1:0] tgt0,
    input  logic [1:0] tgt1,
    input  logic [1:0] tgt2,
    output logic [2:0] grant,
    output logic       done,
    output logic       busy,
    output logic       button_up,
    output logic       button_down,
    output logic [1:0] level
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_STEP = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] c_WAIT_LOAD = 8'(STEP_DELAY - 2);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [1:0] r_idx, w_idx_nxt;
    logic [1:0] r_tgt, w_tgt_nxt;
    logic [1:0] r_level, w_level_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_grant, w_grant_nxt;

    logic [1:0] w_p1, w_p2, w_win, w_sel_tgt, w_step_lvl;
    logic       w_up, w_down, w_req_g;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign w_p1    = inc3(r_ptr);
    assign w_p2    = inc3(w_p1);
    assign w_req_g = req[r_idx];

    always_comb begin
        w_win = w_p2;
        if (req[r_ptr])
            w_win = r_ptr;
        else if (req[w_p1])
            w_win = w_p1;
    end

    always_comb begin
        case (r_idx)
            2'd0:    w_sel_tgt = tgt0;
            2'd1:    w_sel_tgt = tgt1;
            default: w_sel_tgt = tgt2;
        endcase
    end

    // Range guards keep the light inside 0..3 even if the target were corrupted.
    assign w_up   = (r_state == S_STEP) && (r_tgt > r_level) && (r_level != 2'd3);
    assign w_down = (r_state == S_STEP) && (r_tgt < r_level) && (r_level != 2'd0);

    always_comb begin
        w_step_lvl = r_level;
        if (w_up)
            w_step_lvl = r_level + 2'd1;
        else if (w_down)
            w_step_lvl = r_level - 2'd1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        w_tgt_nxt   = r_tgt;
        w_level_nxt = r_level;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_idx_nxt   = w_win;
                    w_grant_nxt = 3'b001 << w_win;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!w_req_g) begin
                    w_grant_nxt = 3'b000;
                    w_ptr_nxt   = inc3(r_idx);
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tgt_nxt   = w_sel_tgt;
                    w_state_nxt = (w_sel_tgt == r_level) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                w_level_nxt = w_step_lvl;
                if (w_step_lvl == r_tgt || !(w_up || w_down)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt   = c_WAIT_LOAD;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_req_g) begin
                    w_grant_nxt = 3'b000;
                    w_ptr_nxt   = inc3(r_idx);
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = S_STEP;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_DONE: begin
                w_grant_nxt = 3'b000;
                w_ptr_nxt   = inc3(r_idx);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_grant_nxt = 3'b000;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_idx   <= 2'd0;
            r_tgt   <= 2'd0;
            r_level <= 2'd0;
            r_cnt   <= 8'd0;
            r_grant <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_tgt   <= w_tgt_nxt;
            r_level <= w_level_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    assign grant       = r_grant;
    assign done        = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign button_up   = w_up;
    assign button_down = w_down;
    assign level       = r_level;

endmodule
`default_nettype wire

// File: tb/tb_light_level_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_light_level_sched
// Brief  : Directed bench for light_level_sched with STEP_DELAY = 4.
// Rev    : 1.0
// ============================================================================
module tb_light_level_sched;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [1:0] tgt0, tgt1, tgt2;
    logic [2:0] grant;
    logic       done, busy, button_up, button_down;
    logic [1:0] level;

    int n_checks = 0;
    int n_errors = 0;

    light_level_sched #(.STEP_DELAY(D)) dut (
        .clk(clk), .rst(rst), .req(req),
        .tgt0(tgt0), .tgt1(tgt1), .tgt2(tgt2),
        .grant(grant), .done(done), .busy(busy),
        .button_up(button_up), .button_down(button_down), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic [1:0] t0, t1, t2;
        logic [2:0] g;
        int         k;
        logic       up;
        logic [1:0] lvl_end;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [8:0] pack(input logic [2:0] g, input logic d, input logic b,
                                        input logic u, input logic dn, input logic [1:0] l);
        return {g, d, b, u, dn, l};
    endfunction

    function automatic logic [8:0] obs();
        return {grant, done, busy, button_up, button_down, level};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the IDLE cycle that samples req; outputs are {grant,done,busy,up,down,level}.
    task automatic run_vec(input int idx, input vec_t v, input logic [1:0] lvl0);
        logic [1:0] lvl;
        int         last;
        logic       pul;
        lvl  = lvl0;
        req  = v.req;
        tgt0 = v.t0;
        tgt1 = v.t1;
        tgt2 = v.t2;
        check($sformatf("v%0d idle", idx), 16'(obs()), 16'(pack(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, lvl)));
        last = (v.k == 0) ? 2 : 3 + (v.k - 1) * D;
        for (int c = 1; c <= last; c++) begin
            tick();
            if (c == 2) begin
                tgt0 = ~v.t0;
                tgt1 = ~v.t1;
                tgt2 = ~v.t2;
            end
            pul = (v.k > 0) && (c >= 2) && (((c - 2) % D) == 0) && (((c - 2) / D) < v.k);
            check($sformatf("v%0d cyc%0d", idx, c), 16'(obs()),
                  16'(pack(v.g, c == last, 1'b1, pul && v.up, pul && !v.up, lvl)));
            if (pul) lvl = v.up ? lvl + 2'd1 : lvl - 2'd1;
        end
        req = 3'b000;
        tick();
        check($sformatf("v%0d end", idx), 16'(obs()), 16'(pack(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, v.lvl_end)));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_g [4];
        logic [1:0] lvl;
        int         w;
        int         idle;

        //           req     t0 t1 t2  grant   k  up  lvl_end
        tbl[0] = '{3'b001, 2'd3, 2'd0, 2'd0, 3'b001, 3, 1'b1, 2'd3};
        tbl[1] = '{3'b010, 2'd0, 2'd0, 2'd1, 3'b010, 3, 1'b0, 2'd0};
        tbl[2] = '{3'b100, 2'd2, 2'd1, 2'd0, 3'b100, 0, 1'b0, 2'd0};
        tbl[3] = '{3'b010, 2'd0, 2'd2, 2'd0, 3'b010, 2, 1'b1, 2'd2};
        tbl[4] = '{3'b011, 2'd1, 2'd3, 2'd0, 3'b001, 1, 1'b0, 2'd1};
        tbl[5] = '{3'b101, 2'd0, 2'd0, 2'd1, 3'b100, 0, 1'b0, 2'd1};
        tbl[6] = '{3'b100, 2'd0, 2'd0, 2'd3, 3'b100, 2, 1'b1, 2'd3};
        exp_g  = '{3'b001, 3'b010, 3'b100, 3'b001};

        // Reset with all requesters active, then contention.
        rst  = 1'b1;
        req  = 3'b111;
        tgt0 = 2'd1;
        tgt1 = 2'd2;
        tgt2 = 2'd3;
        repeat (3) begin
            tick();
            check("reset hold", 16'(obs()), 16'd0);
        end
        rst = 1'b0;
        check("reset release", 16'(obs()), 16'd0);

        for (int i = 0; i < 4; i++) begin
            w = 0;
            while (grant == 3'b000 && w < 20) begin
                tick();
                w++;
            end
            check($sformatf("contend grant%0d", i), 16'(grant), 16'(exp_g[i]));
            if (i < 3) begin
                w = 0;
                while (busy && w < 40) begin
                    tick();
                    w++;
                end
                check($sformatf("contend drop%0d", i), 16'(busy), 16'd0);
                idle = 0;
                while (!busy && idle < 5) begin
                    tick();
                    idle++;
                end
                check($sformatf("contend idle%0d", i), 16'(idle), 16'd1);
            end
        end

        // Asynchronous reset clears a nonzero level at once.
        req = 3'b000;
        rst = 1'b1;
        #1;
        check("async reset", 16'(obs()), 16'd0);
        tick();
        rst = 1'b0;

        lvl = 2'd0;
        for (int i = 0; i < 7; i++) begin
            run_vec(i, tbl[i], lvl);
            lvl = tbl[i].lvl_end;
        end

        // Abort after the first pulse of a 0->3 ramp.
        rst = 1'b1;
        #1;
        tick();
        rst  = 1'b0;
        req  = 3'b001;
        tgt0 = 2'd3;
        tick();
        check("abort load", 16'(obs()), 16'(pack(3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0)));
        tick();
        check("abort pulse", 16'(obs()), 16'(pack(3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0)));
        req = 3'b000;
        for (int c = 3; c <= 14; c++) begin
            tick();
            check($sformatf("abort cyc%0d", c), 16'(obs()),
                  16'(pack((c == 3) ? 3'b001 : 3'b000, 1'b0, c == 3, 1'b0, 1'b0, 2'd1)));
        end
        // Pointer now at 1: requester 1 wins over requester 0.
        req  = 3'b011;
        tgt0 = 2'd0;
        tgt1 = 2'd1;
        tick();
        check("ptr after abort", 16'(obs()), 16'(pack(3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1)));
        tick();
        check("noop done", 16'(obs()), 16'(pack(3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1)));
        req = 3'b000;
        tick();
        check("noop idle", 16'(obs()), 16'(pack(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1)));

        // Reset during WAIT of a 1->3 ramp.
        req  = 3'b001;
        tgt0 = 2'd3;
        tick();
        check("rstwait load", 16'(obs()), 16'(pack(3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1)));
        tick();
        check("rstwait pulse", 16'(obs()), 16'(pack(3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1)));
        tick();
        check("rstwait wait", 16'(obs()), 16'(pack(3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2)));
        rst = 1'b1;
        #1;
        check("rstwait async", 16'(obs()), 16'd0);
        repeat (2) begin
            tick();
            check("rstwait hold", 16'(obs()), 16'd0);
        end
        req = 3'b000;
        rst = 1'b0;
        repeat (6) begin
            tick();
            check("rstwait after", 16'(obs()), 16'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/light_level_sched.md
LIGHT_LEVEL_SCHED -- requirements
Module: light_level_sched

Interface
REQ-001 Parameter: STEP_DELAY, default 4, is the number of clock cycles from one step pulse to the next (legal 2..255).
REQ-002 Port: clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  3  per-requester level-change request; bit i belongs to requester i.
REQ-005 Port: tgt0, tgt1, tgt2  input  2 each  target light level (0..3) of requester 0/1/2.
REQ-006 Port: grant  output  3  one-hot, registered; marks the requester being served.
REQ-007 Port: done  output  1  single-cycle pulse; the granted request has completed.
REQ-008 Port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 Port: button_up, button_down  output  1 each  single-cycle step pulses that drive the 4-level light's up and down inputs.
REQ-010 Port: level  output  2  mirror of the light's current level (0..3).

Function
REQ-011 The FSM SHALL have states IDLE, LOAD, STEP, WAIT and DONE, all registered.
REQ-012 In IDLE, the FSM SHALL sample req; if any bit is set, it SHALL pick a requester round-robin, starting from the priority pointer, and enter LOAD.
REQ-013 The priority pointer SHALL reset to 0; on exit from DONE or on abort, it SHALL move to (served index + 1) mod 3.
REQ-014 In LOAD, the FSM SHALL raise the winner's grant bit and latch its tgt; the target SHALL NOT be resampled afterwards.
REQ-015 From LOAD: if the latched target equals level, the FSM SHALL go to DONE; otherwise it SHALL go to STEP.
REQ-016 STEP SHALL last exactly 1 cycle and assert exactly one of these:
- button_up if target > level;
- button_down if target < level.
REQ-017 In the same STEP cycle, level SHALL increment or decrement by 1.
REQ-018 button_up and button_down SHALL never be high in the same cycle, and SHALL be low outside STEP.
REQ-019 After a STEP, the FSM SHALL go to DONE if the updated level equals the target; otherwise it SHALL go to WAIT.
REQ-020 WAIT SHALL last exactly STEP_DELAY-1 cycles and then return to STEP, so that pulses are spaced exactly STEP_DELAY cycles apart.
REQ-021 level SHALL never be stepped below 0 or above 3; no pulse is issued beyond those limits.
REQ-022 Timing for a request sampled in IDLE at cycle t, with k = |target - level|:
- LOAD at t+1;
- pulses at t+2+n*STEP_DELAY for n = 0..k-1;
- done at t+3+(k-1)*STEP_DELAY, or at t+2 when k = 0.
REQ-023 grant SHALL stay high from LOAD through DONE inclusive, and DONE SHALL always return to IDLE.
REQ-024 Abort: if the granted req bit is low in a LOAD or WAIT cycle, the FSM SHALL:
- go straight to IDLE;
- issue no further pulses;
- not assert done;
- keep level.
REQ-025 req bits of requesters that are not granted SHALL be ignored until IDLE.
REQ-026 Each tgt value SHALL be used as unsigned 2-bit, and the WAIT counter SHALL be 8 bits.

Reset
REQ-027 While rst is high, the block SHALL hold:
- state = IDLE, pointer = 0, level = 0 (matching the light's reset level);
- grant = 0;
- done, busy, button_up and button_down = 0.
REQ-028 rst asserted mid-ramp SHALL abandon the operation immediately with no residual pulse, and the requester SHALL re-request after reset.

Verification (STEP_DELAY = 4)
REQ-029 Reset: pulse rst with req = 3'b111 -> all outputs 0 during and after reset until the first IDLE sample.
REQ-030 Ramp up: req0 with tgt0 = 3, sampled at cycle 0 ->
- grant = 001 at cycle 1;
- button_up at cycles 2, 6 and 10;
- done at cycle 11;
- level = 3.
REQ-031 Ramp down: from level 3, req1 with tgt1 = 0 -> three button_down pulses 4 cycles apart, then level = 0 and done.
REQ-032 Contention: req = 111 held after reset, all targets different -> grants in order 001, 010, 100, then 001, with busy dropping for exactly one IDLE cycle between grants.
REQ-033 No-op: target equals level -> done at t+2, no button pulses.
REQ-034 Abort and reset:
- req0 dropped after the first pulse of a 0->3 ramp -> level = 1, no further pulses, no done, pointer moves to 1;
- rst during WAIT -> level = 0, no pulse.
